pgm_sound_mailbox: RTL and testbench
====================================

# pgm_sound_mailbox

Parametrised 68k↔Z80 command/reply mailbox for the PGM sound subsystem. It replaces the fixed three single-byte sound latches with NUM_CH channels. Each channel has a 68k→Z80 command FIFO and a Z80→68k reply register, plus per-channel status, sticky overflow flags and interrupt generation toward both CPUs. It sits between the 68k address decode (C00000 region) and the Z80 I/O decode. Both bus adapters present single-cycle strobes synchronous to the same clock.

## Interface
Parameters:
- NUM_CH, 3: number of channels, 1..DATA_W/2
- DATA_W, 8: data width of commands and replies
- DEPTH, 4: command FIFO entries per channel, power of two, ≥2

Ports:
- fixed_20m_clk  in  1  sole clock
- reset_n  in  1  reset, asynchronous assert, active-low
- m_wr  in  1  68k write strobe, one cycle per bus access
- m_rd  in  1  68k read strobe, one cycle per bus access
- m_sts  in  1  68k access targets the status register instead of a channel
- m_ch  in  CH_W  68k channel index, CH_W = max(1, clog2(NUM_CH))
- m_din  in  DATA_W  68k write data
- m_dout  out  DATA_W  68k read data, registered
- z_wr, z_rd, z_sts  in  1  Z80 strobes, same meaning as the 68k strobes
- z_ch  in  CH_W  Z80 channel index
- z_din  in  DATA_W  Z80 write data
- z_dout  out  DATA_W  Z80 read data, registered
- z_int_n  out  1  Z80 interrupt, active-low, registered
- m_irq  out  1  68k reply-pending interrupt, active-high, registered
- ovf  out  NUM_CH  sticky command-overflow flags, registered

## Operation
- 68k channel write pushes m_din into cmd FIFO[m_ch].
  - If the FIFO is full, the data is dropped and ovf[m_ch] is set.
- Z80 channel read pops the head of cmd FIFO[z_ch] into z_dout.
  - If the FIFO is empty, z_dout is all-ones and no pop occurs.
- Z80 channel write loads reply[z_ch] and sets rvalid[z_ch].
  - If rvalid was already set, the old value is overwritten and rovf[z_ch] is set.
- 68k channel read returns reply[m_ch] and clears rvalid[m_ch].
  - If rvalid was clear, the read still returns the reply register contents.
- 68k status read returns bits [NUM_CH-1:0] = rvalid and bits [2·NUM_CH-1:NUM_CH] = ovf. Upper bits read 0.
- 68k status write clears ovf bits where m_din[NUM_CH+i]=1 (write-1-to-clear). It clears rovf where m_din[i]=1.
- Z80 status read returns [NUM_CH-1:0] = cmd non-empty and [2·NUM_CH-1:NUM_CH] = rovf. Upper bits read 0.
- Z80 status write: bit0 sets int_en, the Z80 interrupt enable. Other bits are ignored.
- z_int_n is low when int_en and any cmd FIFO is non-empty.
- m_irq is high when any rvalid is set.
- m_ch or z_ch ≥ NUM_CH: writes are ignored, reads return all-ones, no state changes.

## Timing
- Reset values:
  - all FIFOs empty
  - rvalid, ovf, rovf = 0
  - int_en = 0
  - m_dout, z_dout = all-ones
  - z_int_n = 1, m_irq = 0
- Read latency is 1 cycle. Data is valid on the edge after the strobe and holds until the next read strobe on the same side.
- Flags, counts, z_int_n, m_irq and ovf update on the same edge as the causing strobe.
- Same-cycle push and pop on one channel:
  - Both take effect.
  - On a full FIFO, the push is accepted with no overflow and the count is unchanged.
  - On an empty FIFO, the pop returns all-ones and the push lands, leaving count = 1.
- Same-cycle Z80 reply write and 68k reply read on one channel:
  - The 68k gets the old value.
  - rvalid ends set with the new value.
  - rovf is set only if rvalid was set before the edge.
- Same-cycle overflow set and write-1-to-clear on the same ovf bit: the set wins.
- If m_wr and m_rd are high together, only m_wr is honoured. The Z80 side follows the same rule.
- Reset mid-operation clears all state immediately (asynchronously). Pending data is lost.

## Structure
- Package pgm_mbox_pkg holds:
  - the clog2-based CH_W helper function
  - status bit-position functions
  - the all-ones EMPTY_DATA constant
- Sub-module pgm_mbox_fifo is a single-clock FIFO with parameters DATA_W and DEPTH.
  - It exposes push, pop, dout, empty and full.
  - It uses a count of clog2(DEPTH)+1 bits and pointers that wrap modulo DEPTH.
- The top module instantiates NUM_CH FIFOs in a generate loop.

## Test plan
- Reset → z_int_n=1, m_irq=0, ovf=0, a Z80 status read returns 0x00.
- Z80 status write 0x01. Then 68k writes 0x11, 0x22 to ch1 → z_int_n low after the first write edge. Z80 reads ch1 twice → 0x11 then 0x22, then z_int_n=1. A third read returns 0xFF.
- DEPTH=4: five 68k writes to ch0 (0xA0..0xA4) → ovf[0]=1. The Z80 drains 0xA0..0xA3. A 68k status write of 0x08 (NUM_CH=3) clears ovf[0].
- Fill ch2, then issue a push of 0x55 and a pop on the same cycle → the pop returns the oldest entry, ovf stays 0, and 0x55 is the last entry drained.
- Z80 writes 0x7E then 0x7F to ch0 → m_irq=1 and Z80 status bit3 (rovf[0]) =1. A 68k read of ch0 returns 0x7F and m_irq falls.
- Assert reset_n low mid-burst with ch1 holding 2 entries → all outputs return to reset values and z_int_n=1 in the same cycle.

Source files
------------

// File: rtl/pgm_mbox_pkg.sv
// pgm_mbox_pkg
// Shared helpers for the PGM sound mailbox:
//   - ch_width()   : width of a channel index, never less than 1 bit
//   - sts_lo_bit() : status bit carrying a per-channel "low half" flag
//                    (rvalid on the 68k side, cmd non-empty on the Z80 side)
//   - sts_hi_bit() : status bit carrying a per-channel "high half" flag
//                    (ovf on the 68k side, rovf on the Z80 side)
//   - EMPTY_DATA   : all-ones read value for empty FIFOs / unmapped channels
package pgm_mbox_pkg;

  localparam int MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] EMPTY_DATA = '1;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int sts_lo_bit(input int ch);
    return ch;
  endfunction

  function automatic int sts_hi_bit(input int num_ch, input int ch);
    return num_ch + ch;
  endfunction

endpackage

// File: rtl/pgm_mbox_fifo.sv
// pgm_mbox_fifo
// Single-clock command FIFO, one per mailbox channel.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i, din_i : write strobe and data
//   pop_i         : read strobe; dout_o shows the head combinationally
//   empty_o/full_o: occupancy flags for the current cycle
//   empty_nxt_o   : occupancy after this edge, for registered interrupts
// The caller only pushes when not full (or when popping in the same cycle)
// and only pops when not empty; the FIFO does not re-check this.
module pgm_mbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              empty_nxt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;  // idle, or push+pop cancel out
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is governed
  // by count_q, so stale entries are never observable and the array can map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // When full with push+pop, wr_ptr == rd_ptr: the head is read before the
  // edge and overwritten at the edge, which is exactly the intended order.
  assign dout_o      = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_nxt_o = (count_d == '0);

endmodule

// File: rtl/pgm_sound_mailbox.sv
// pgm_sound_mailbox
// 68k <-> Z80 command/reply mailbox for the PGM sound subsystem.
// Each of NUM_CH channels has a 68k->Z80 command FIFO and a Z80->68k reply
// register with a valid flag, plus sticky overflow flags and interrupts.
// Ports:
//   fixed_20m_clk, reset_n         : clock, asynchronous active-low reset
//   m_wr, m_rd, m_sts, m_ch, m_din : 68k single-cycle access strobes/data
//   m_dout                         : 68k read data (registered)
//   z_wr, z_rd, z_sts, z_ch, z_din : Z80 single-cycle access strobes/data
//   z_dout                         : Z80 read data (registered)
//   z_int_n                        : Z80 interrupt, active-low (registered)
//   m_irq                          : 68k reply-pending interrupt (registered)
//   ovf                            : sticky command-overflow flags
module pgm_sound_mailbox
  import pgm_mbox_pkg::*;
#(
  parameter  int NUM_CH = 3,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              fixed_20m_clk,
  input  logic              reset_n,
  input  logic              m_wr,
  input  logic              m_rd,
  input  logic              m_sts,
  input  logic [CH_W-1:0]   m_ch,
  input  logic [DATA_W-1:0] m_din,
  output logic [DATA_W-1:0] m_dout,
  input  logic              z_wr,
  input  logic              z_rd,
  input  logic              z_sts,
  input  logic [CH_W-1:0]   z_ch,
  input  logic [DATA_W-1:0] z_din,
  output logic [DATA_W-1:0] z_dout,
  output logic              z_int_n,
  output logic              m_irq,
  output logic [NUM_CH-1:0] ovf
);

  localparam logic [DATA_W-1:0] ALL_ONES = EMPTY_DATA[DATA_W-1:0];

  // ---------------------------------------------------------------------------
  // Access decode. A simultaneous write and read on one side is a write.
  // Status accesses ignore the channel index.
  // ---------------------------------------------------------------------------
  logic m_ok, z_ok;
  logic m_ch_wr, m_ch_rd, m_st_wr, m_st_rd, m_rd_any;
  logic z_ch_wr, z_ch_rd, z_st_wr, z_st_rd, z_rd_any;

  always_comb begin
    m_ok     = (int'(m_ch) < NUM_CH);
    z_ok     = (int'(z_ch) < NUM_CH);
    m_rd_any = m_rd & ~m_wr;
    z_rd_any = z_rd & ~z_wr;
    m_ch_wr  = m_wr     & ~m_sts & m_ok;
    m_ch_rd  = m_rd_any & ~m_sts & m_ok;
    m_st_wr  = m_wr     &  m_sts;
    m_st_rd  = m_rd_any &  m_sts;
    z_ch_wr  = z_wr     & ~z_sts & z_ok;
    z_ch_rd  = z_rd_any & ~z_sts & z_ok;
    z_st_wr  = z_wr     &  z_sts;
    z_st_rd  = z_rd_any &  z_sts;
  end

  // ---------------------------------------------------------------------------
  // Command FIFOs
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] push, pop, empty, full, empty_nxt, ovf_set;
  logic [DATA_W-1:0] fifo_dout [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic m_sel, z_sel;
    assign m_sel = m_ch_wr & (m_ch == CH_W'(c));
    assign z_sel = z_ch_rd & (z_ch == CH_W'(c));

    // A pop in the same cycle frees the slot the push needs, so a full FIFO
    // only overflows when nothing is being drained.
    assign pop[c]     = z_sel & ~empty[c];
    assign push[c]    = m_sel & (~full[c] | pop[c]);
    assign ovf_set[c] = m_sel & full[c] & ~pop[c];

    pgm_mbox_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk         (fixed_20m_clk),
      .rst_n       (reset_n),
      .push_i      (push[c]),
      .din_i       (m_din),
      .pop_i       (pop[c]),
      .dout_o      (fifo_dout[c]),
      .empty_o     (empty[c]),
      .full_o      (full[c]),
      .empty_nxt_o (empty_nxt[c])
    );
  end

  // ---------------------------------------------------------------------------
  // Reply registers, flags and read data
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] reply_q [NUM_CH];
  logic [DATA_W-1:0] reply_d [NUM_CH];
  logic [NUM_CH-1:0] rvalid_q, rvalid_d, rovf_q, rovf_d, ovf_q, ovf_d;
  logic              int_en_q, int_en_d;
  logic [DATA_W-1:0] m_dout_q, m_rdata, z_dout_q, z_rdata;
  logic              z_int_n_q, m_irq_q;

  always_comb begin
    int_en_d = z_st_wr ? z_din[0] : int_en_q;

    for (int c = 0; c < NUM_CH; c++) begin
      logic zw, mr;
      zw = z_ch_wr & (z_ch == CH_W'(c));
      mr = m_ch_rd & (m_ch == CH_W'(c));

      reply_d[c]  = zw ? z_din : reply_q[c];
      // A Z80 write beats a same-cycle 68k read: the 68k takes the old value
      // and the new one stays pending.
      rvalid_d[c] = zw | (rvalid_q[c] & ~mr);
      // Set wins over write-1-to-clear on both sticky flags.
      rovf_d[c]   = (rovf_q[c] & ~(m_st_wr & m_din[sts_lo_bit(c)]))
                  | (zw & rvalid_q[c]);
      ovf_d[c]    = (ovf_q[c] & ~(m_st_wr & m_din[sts_hi_bit(NUM_CH, c)]))
                  | ovf_set[c];
    end
  end

  always_comb begin
    m_rdata = ALL_ONES;
    if (m_st_rd) begin
      m_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_rdata[sts_lo_bit(c)]         = rvalid_q[c];
        m_rdata[sts_hi_bit(NUM_CH, c)] = ovf_q[c];
      end
    end else if (m_ch_rd) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_ch == CH_W'(c)) m_rdata = reply_q[c];
      end
    end
  end

  always_comb begin
    z_rdata = ALL_ONES;
    if (z_st_rd) begin
      z_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        z_rdata[sts_lo_bit(c)]         = ~empty[c];
        z_rdata[sts_hi_bit(NUM_CH, c)] = rovf_q[c];
      end
    end else if (z_ch_rd) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (z_ch == CH_W'(c) && !empty[c]) z_rdata = fifo_dout[c];
      end
    end
  end

  always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) reply_q[c] <= '0;
      rvalid_q  <= '0;
      rovf_q    <= '0;
      ovf_q     <= '0;
      int_en_q  <= 1'b0;
      m_dout_q  <= ALL_ONES;
      z_dout_q  <= ALL_ONES;
      z_int_n_q <= 1'b1;
      m_irq_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) reply_q[c] <= reply_d[c];
      rvalid_q <= rvalid_d;
      rovf_q   <= rovf_d;
      ovf_q    <= ovf_d;
      int_en_q <= int_en_d;
      // Read data holds until the next read strobe on the same side.
      if (m_rd_any) m_dout_q <= m_rdata;
      if (z_rd_any) z_dout_q <= z_rdata;
      // Interrupts are computed from next-state so they move on the same
      // edge as the access that causes them.
      z_int_n_q <= ~(int_en_d & |(~empty_nxt));
      m_irq_q   <= |rvalid_d;
    end
  end

  assign m_dout  = m_dout_q;
  assign z_dout  = z_dout_q;
  assign z_int_n = z_int_n_q;
  assign m_irq   = m_irq_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Directed self-checking bench for pgm_sound_mailbox (NUM_CH=3, DATA_W=8,
// DEPTH=4). Expected values are hand-computed constants.
module tb_pgm_sound_mailbox;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_wr, m_rd, m_sts, z_wr, z_rd, z_sts;
  logic [1:0] m_ch, z_ch;
  logic [7:0] m_din, z_din, m_dout, z_dout;
  logic       z_int_n, m_irq;
  logic [2:0] ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pgm_sound_mailbox #(
    .NUM_CH (3),
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .fixed_20m_clk (clk),
    .reset_n       (reset_n),
    .m_wr          (m_wr),
    .m_rd          (m_rd),
    .m_sts         (m_sts),
    .m_ch          (m_ch),
    .m_din         (m_din),
    .m_dout        (m_dout),
    .z_wr          (z_wr),
    .z_rd          (z_rd),
    .z_sts         (z_sts),
    .z_ch          (z_ch),
    .z_din         (z_din),
    .z_dout        (z_dout),
    .z_int_n       (z_int_n),
    .m_irq         (m_irq),
    .ovf           (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: strobes set up beforehand are sampled on this edge, outputs
  // are observed 1 time unit later, then all strobes drop.
  task automatic tick();
    @(posedge clk);
    #1;
    m_wr = 1'b0; m_rd = 1'b0; m_sts = 1'b0;
    z_wr = 1'b0; z_rd = 1'b0; z_sts = 1'b0;
  endtask

  task automatic m_write(input logic sts, input logic [1:0] ch, input logic [7:0] d);
    m_wr = 1'b1; m_sts = sts; m_ch = ch; m_din = d;
    tick();
  endtask

  task automatic m_read(input logic sts, input logic [1:0] ch);
    m_rd = 1'b1; m_sts = sts; m_ch = ch;
    tick();
  endtask

  task automatic z_write(input logic sts, input logic [1:0] ch, input logic [7:0] d);
    z_wr = 1'b1; z_sts = sts; z_ch = ch; z_din = d;
    tick();
  endtask

  task automatic z_read(input logic sts, input logic [1:0] ch);
    z_rd = 1'b1; z_sts = sts; z_ch = ch;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    m_wr = 0; m_rd = 0; m_sts = 0; m_ch = 0; m_din = 0;
    z_wr = 0; z_rd = 0; z_sts = 0; z_ch = 0; z_din = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ---- reset state ----
    check("rst_z_int_n", z_int_n, 1);
    check("rst_m_irq",   m_irq,   0);
    check("rst_ovf",     ovf,     0);
    check("rst_m_dout",  m_dout,  8'hFF);
    check("rst_z_dout",  z_dout,  8'hFF);
    z_read(1, 0);
    check("rst_z_status", z_dout, 8'h00);

    // ---- basic command path with interrupt ----
    z_write(1, 0, 8'h01);
    check("int_en_no_cmd", z_int_n, 1);
    m_write(0, 1, 8'h11);
    check("int_after_1st", z_int_n, 0);
    m_write(0, 1, 8'h22);
    z_read(1, 0);
    check("z_status_ch1", z_dout, 8'h02);
    z_read(0, 1);
    check("ch1_rd0", z_dout, 8'h11);
    check("ch1_int_still", z_int_n, 0);
    z_read(0, 1);
    check("ch1_rd1", z_dout, 8'h22);
    check("ch1_int_clear", z_int_n, 1);
    z_read(0, 1);
    check("ch1_empty_rd", z_dout, 8'hFF);

    // ---- overflow on ch0 ----
    for (int i = 0; i < 4; i++) m_write(0, 0, 8'hA0 + 8'(i));
    check("ovf_full_no_ovf", ovf, 3'b000);
    m_write(0, 0, 8'hA4);
    check("ovf_set", ovf, 3'b001);
    m_read(1, 0);
    check("m_status_ovf", m_dout, 8'h08);
    for (int i = 0; i < 4; i++) begin
      z_read(0, 0);
      check($sformatf("ovf_drain%0d", i), z_dout, 8'hA0 + 8'(i));
    end
    z_read(0, 0);
    check("ovf_drain_empty", z_dout, 8'hFF);
    m_write(1, 0, 8'h08);
    check("ovf_w1c", ovf, 3'b000);

    // ---- push+pop on a full FIFO ----
    for (int i = 0; i < 4; i++) m_write(0, 2, 8'hC0 + 8'(i));
    m_wr = 1; m_ch = 2; m_din = 8'h55;
    z_rd = 1; z_ch = 2;
    tick();
    check("full_pp_dout", z_dout, 8'hC0);
    check("full_pp_ovf",  ovf,    3'b000);
    for (int i = 1; i < 4; i++) begin
      z_read(0, 2);
      check($sformatf("full_pp_drain%0d", i), z_dout, 8'hC0 + 8'(i));
    end
    z_read(0, 2);
    check("full_pp_last", z_dout, 8'h55);

    // ---- push+pop on an empty FIFO ----
    m_wr = 1; m_ch = 2; m_din = 8'h66;
    z_rd = 1; z_ch = 2;
    tick();
    check("empty_pp_dout", z_dout, 8'hFF);
    z_read(1, 0);
    check("empty_pp_status", z_dout, 8'h04);
    z_read(0, 2);
    check("empty_pp_data", z_dout, 8'h66);

    // ---- replies and reply overflow ----
    z_write(0, 0, 8'h7E);
    check("reply_irq", m_irq, 1);
    z_write(0, 0, 8'h7F);
    z_read(1, 0);
    check("rovf_status", z_dout, 8'h08);
    m_read(0, 0);
    check("reply_data", m_dout, 8'h7F);
    check("reply_irq_clr", m_irq, 0);
    m_read(1, 0);
    check("m_status_idle", m_dout, 8'h00);
    m_write(1, 0, 8'h01);
    z_read(1, 0);
    check("rovf_w1c", z_dout, 8'h00);

    // ---- Z80 write and 68k read of the same reply in one cycle ----
    z_write(0, 1, 8'h31);
    z_wr = 1; z_ch = 1; z_din = 8'h32;
    m_rd = 1; m_ch = 1;
    tick();
    check("race_old_value", m_dout, 8'h31);
    check("race_irq_kept",  m_irq,  1);
    z_read(1, 0);
    check("race_rovf", z_dout, 8'h10);
    m_read(0, 1);
    check("race_new_value", m_dout, 8'h32);
    m_write(1, 0, 8'h02);

    // ---- out-of-range channel and write-over-read priority ----
    m_write(0, 3, 8'h99);
    z_read(1, 0);
    check("oor_no_push", z_dout, 8'h00);
    m_read(0, 3);
    check("oor_m_rd", m_dout, 8'hFF);
    z_write(0, 3, 8'h12);
    check("oor_no_reply", m_irq, 0);
    z_read(0, 3);
    check("oor_z_rd", z_dout, 8'hFF);
    m_wr = 1; m_rd = 1; m_ch = 0; m_din = 8'h44;
    tick();
    check("wr_over_rd_hold", m_dout, 8'hFF);
    z_read(0, 0);
    check("wr_over_rd_data", z_dout, 8'h44);

    // ---- asynchronous reset mid-burst ----
    for (int i = 0; i < 5; i++) m_write(0, 1, 8'hD0 + 8'(i));
    z_write(0, 2, 8'h5A);
    check("pre_rst_ovf",   ovf,     3'b010);
    check("pre_rst_int",   z_int_n, 0);
    check("pre_rst_irq",   m_irq,   1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_z_int_n", z_int_n, 1);
    check("arst_m_irq",   m_irq,   0);
    check("arst_ovf",     ovf,     0);
    check("arst_z_dout",  z_dout,  8'hFF);
    check("arst_m_dout",  m_dout,  8'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    z_read(1, 0);
    check("post_rst_status", z_dout, 8'h00);
    z_read(0, 1);
    check("post_rst_ch1", z_dout, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
